counter9999_ctrl: RTL and testbench

//   Run/stop controller and BCD count datapath for the 0000-9999 counter.

---
 rtl/counter9999_pkg.sv | 20 ++
 rtl/counter9999_ctrl_bcd_digit.sv | 25 ++
 rtl/counter9999_ctrl.sv | 139 +++++++++++++
 tb/tb_counter9999_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/counter9999_pkg.sv
// rtl/counter9999_pkg.sv - shared state encoding and constants for the BCD counter
package counter9999_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam int         DEFAULT_DIGITS = 4;

  // RUN and LAP both advance the live count; LAP only freezes what is shown.
  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/counter9999_ctrl_bcd_digit.sv
// rtl/counter9999_ctrl_bcd_digit.sv - one BCD decade with carry-out
module bcd_digit
  import counter9999_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       co
);

  // Carry is combinational so a whole ripple of 9s rolls over in one clock.
  assign co = inc & (q == BCD_MAX);

  // Decade register: clear dominates, 9 + inc rolls to 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/counter9999_ctrl.sv
// rtl/counter9999_ctrl.sv - run/stop/lap controller and BCD count datapath
module counter9999_ctrl
  import counter9999_pkg::*;
#(
  parameter int   DIGITS      = DEFAULT_DIGITS,
  parameter logic STOP_AT_MAX = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  btn_ss,
  input  logic                  btn_clr,
  input  logic                  btn_lap,
  output logic [4*DIGITS-1:0]   cnt,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  running,
  output logic                  wrap
);

  state_t              state;
  logic [4*DIGITS-1:0] lap_reg;
  logic                prev_ss;
  logic                prev_clr;
  logic                prev_lap;

  logic                raw_ss;
  logic                raw_clr;
  logic                raw_lap;
  logic                press_clr;
  logic                press_ss;
  logic                press_lap;

  logic [DIGITS:0]     carry;
  logic [DIGITS-1:0]   nine;
  logic                at_max;
  logic                count_en;
  logic                hold_max;

  // Rising-edge detect; history resets high so a button held through reset is not a press.
  assign raw_ss  = btn_ss  & ~prev_ss;
  assign raw_clr = btn_clr & ~prev_clr;
  assign raw_lap = btn_lap & ~prev_lap;

  // Same-cycle priority clr > ss > lap; losers are simply dropped.
  assign press_clr = raw_clr;
  assign press_ss  = raw_ss & ~raw_clr;
  assign press_lap = raw_lap & ~raw_clr & ~raw_ss;

  // Count decision looks at the pre-transition state; clear suppresses the tick.
  assign count_en = tick & is_counting(state) & ~press_clr;
  assign hold_max = STOP_AT_MAX & at_max;
  assign carry[0] = count_en & ~hold_max;
  assign at_max   = &nine;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nine[gi] = (cnt[4*gi +: 4] == BCD_MAX);

      bcd_digit u_digit (
        .clk (clk),
        .rst (rst),
        .clr (press_clr),
        .inc (carry[gi]),
        .q   (cnt[4*gi +: 4]),
        .co  (carry[gi+1])
      );
    end
  endgenerate

  // Button history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ss  <= 1'b1;
      prev_clr <= 1'b1;
      prev_lap <= 1'b1;
    end else begin
      prev_ss  <= btn_ss;
      prev_clr <= btn_clr;
      prev_lap <= btn_lap;
    end
  end

  // Rollover pulse: carry out of the top decade only exists when wrapping is allowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= carry[DIGITS];
    end
  end

  // Run/pause/lap/done sequencing and lap snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      lap_reg <= '0;
    end else if (press_clr) begin
      state   <= ST_IDLE;
      lap_reg <= '0;
    end else if (count_en && hold_max) begin
      state <= ST_DONE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (press_ss) state <= ST_RUN;
        end
        ST_RUN: begin
          if (press_ss) begin
            state <= ST_PAUSE;
          end else if (press_lap) begin
            state   <= ST_LAP;
            lap_reg <= cnt;
          end
        end
        ST_PAUSE: begin
          if (press_ss) state <= ST_RUN;
        end
        ST_LAP: begin
          if (press_ss) begin
            state <= ST_PAUSE;
          end else if (press_lap) begin
            state <= ST_RUN;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign disp    = (state == ST_LAP) ? lap_reg : cnt;
  assign running = is_counting(state);

endmodule

// File: tb/tb_counter9999_ctrl.sv
// tb/tb_counter9999_ctrl.sv - vector/scoreboard bench for counter9999_ctrl
module tb_counter9999_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        btn_ss = 1'b0;
  logic        btn_clr = 1'b0;
  logic        btn_lap = 1'b0;

  logic [15:0] cnt0, disp0, cnt1, disp1;
  logic        run0, wrap0, run1, wrap1;

  int n_cmp = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  counter9999_ctrl #(.DIGITS(4), .STOP_AT_MAX(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .btn_lap(btn_lap), .cnt(cnt0), .disp(disp0), .running(run0), .wrap(wrap0)
  );

  counter9999_ctrl #(.DIGITS(4), .STOP_AT_MAX(1'b1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .btn_lap(btn_lap), .cnt(cnt1), .disp(disp1), .running(run1), .wrap(wrap1)
  );

  typedef struct {
    logic        rst, tick, ss, clr, lap;
    logic [15:0] cnt0, disp0;
    logic        run0, wrap0;
    logic [15:0] cnt1, disp1;
    logic        run1, wrap1;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic logic [15:0] bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic vec_t mk(input logic t, input logic s, input logic c, input logic l,
                              input logic [15:0] ec, input logic [15:0] ed,
                              input logic er, input logic ew, input string nm);
    vec_t v;
    v.rst = 1'b0; v.tick = t; v.ss = s; v.clr = c; v.lap = l;
    v.cnt0 = ec; v.disp0 = ed; v.run0 = er; v.wrap0 = ew;
    v.cnt1 = ec; v.disp1 = ed; v.run1 = er; v.wrap1 = ew;
    v.name = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    rst = v.rst; tick = v.tick; btn_ss = v.ss; btn_clr = v.clr; btn_lap = v.lap;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.name, ".cnt0"},  cnt0,  e.cnt0);
    chk({e.name, ".disp0"}, disp0, e.disp0);
    chk({e.name, ".run0"},  16'(run0),  16'(e.run0));
    chk({e.name, ".wrap0"}, 16'(wrap0), 16'(e.wrap0));
    chk({e.name, ".cnt1"},  cnt1,  e.cnt1);
    chk({e.name, ".disp1"}, disp1, e.disp1);
    chk({e.name, ".run1"},  16'(run1),  16'(e.run1));
    chk({e.name, ".wrap1"}, 16'(wrap1), 16'(e.wrap1));
  endtask

  // Every decade of both counters must stay a legal BCD digit.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 4; d++) begin
        n_cmp++;
        if (cnt0[4*d +: 4] > 4'd9 || cnt1[4*d +: 4] > 4'd9) begin
          n_fail++;
          $display("FAIL digit_range: digit %0d got %h / %h expected <= 9", d, cnt0, cnt1);
        end
      end
    end
  end

  initial begin
    vec_t v;

    // Reset with start/stop held high, then release while still held.
    v = mk(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, "t1_rst_a"); v.rst = 1'b1; vecs.push_back(v);
    v = mk(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, "t1_rst_b"); v.rst = 1'b1; vecs.push_back(v);
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, "t1_held"));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, "t1_release"));

    // Start, count 12, pause, ignored ticks, resume.
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, "t2_start"));
    for (int i = 1; i <= 12; i++) vecs.push_back(mk(1, 0, 0, 0, bcd(i), bcd(i), 1, 0, "t2_count"));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0012, 16'h0012, 0, 0, "t2_pause"));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 16'h0012, 16'h0012, 0, 0, "t2_paused_tick"));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0012, 16'h0012, 1, 0, "t2_resume"));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0013, 16'h0013, 1, 0, "t2_tick13"));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0014, 16'h0014, 0, 0, "ss_tick_same"));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0014, 16'h0014, 0, 0, "rel_a"));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0014, 16'h0014, 1, 0, "held_ss_a"));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0014, 16'h0014, 1, 0, "held_ss_b"));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0014, 16'h0014, 1, 0, "rel_b"));

    // Lap freeze at 41 while counting to 46, then unfreeze.
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, "t3_clr"));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, "t3_start"));
    for (int i = 1; i <= 41; i++) vecs.push_back(mk(1, 0, 0, 0, bcd(i), bcd(i), 1, 0, "t3_count"));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0041, 16'h0041, 1, 0, "t3_lap"));
    for (int i = 42; i <= 46; i++) vecs.push_back(mk(1, 0, 0, 0, bcd(i), 16'h0041, 1, 0, "t3_lap_tick"));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0046, 16'h0046, 1, 0, "t3_unlap"));

    // Priority: clr+ss+tick, then ss+lap, then ss out of LAP.
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, "t5_clr"));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, "t5_start"));
    for (int i = 1; i <= 7; i++) vecs.push_back(mk(1, 0, 0, 0, bcd(i), bcd(i), 1, 0, "t5_count"));
    vecs.push_back(mk(1, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, "t5_clr_ss_tick"));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, "t5_idle_tick"));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, "t5_restart"));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0001, 16'h0001, 1, 0, "t5_tick"));
    vecs.push_back(mk(0, 1, 0, 1, 16'h0001, 16'h0001, 0, 0, "t5_ss_lap"));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, "t5_paused"));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0001, 16'h0001, 1, 0, "t5_run"));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0001, 16'h0001, 1, 0, "t5_lap"));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0002, 16'h0001, 1, 0, "t5_lap_tick"));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0002, 16'h0002, 0, 0, "t5_lap_ss"));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0002, 16'h0002, 0, 0, "t5_pause_lap"));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0002, 16'h0002, 0, 0, "t5_rel"));

    foreach (vecs[k]) begin
      step(vecs[k]);
      if (k == 1) mon_en = 1'b1;
    end

    // Count to the top: carries at 0100 and 1000, then wrap vs. stop.
    step(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, "m_clr"));
    step(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, "m_start"));
    for (int i = 1; i <= 9999; i++)
      step(mk(1, 0, 0, 0, bcd(i), bcd(i), 1, 0, (i == 100 || i == 1000) ? "m_carry" : "m_count"));
    v = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, "m_max_tick");
    v.cnt1 = 16'h9999; v.disp1 = 16'h9999; v.run1 = 1'b0; v.wrap1 = 1'b0; step(v);
    v = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, "m_after");
    v.cnt1 = 16'h9999; v.disp1 = 16'h9999; v.run1 = 1'b0; step(v);
    v = mk(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, "m_ss_a");
    v.cnt1 = 16'h9999; v.disp1 = 16'h9999; v.run1 = 1'b0; step(v);
    v = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, "m_tick_a");
    v.cnt1 = 16'h9999; v.disp1 = 16'h9999; v.run1 = 1'b0; step(v);
    v = mk(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, "m_ss_b");
    v.cnt1 = 16'h9999; v.disp1 = 16'h9999; v.run1 = 1'b0; step(v);
    step(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, "m_done_clr"));
    step(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, "m_restart"));
    step(mk(1, 0, 0, 0, 16'h0001, 16'h0001, 1, 0, "m_tick1"));

    // Reset mid-run with start/stop held: everything discarded, no press on release.
    v = mk(1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, "r_mid_rst"); v.rst = 1'b1; step(v);
    step(mk(1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, "r_held"));
    step(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, "r_rel"));

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
